// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for a shared cosine engine.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module cordic_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid0,
    input  logic        req_valid1,
    input  logic [21:0] req_angle0,
    input  logic [21:0] req_angle1,
    output logic        req_ready0,
    output logic        req_ready1,
    output logic        resp_valid0,
    output logic        resp_valid1,
    input  logic        resp_ready0,
    input  logic        resp_ready1,
    output logic [21:0] resp_cos,
    output logic        resp_err,
    output logic        eng_start,
    output logic [21:0] eng_angle,
    input  logic        eng_done,
    input  logic [21:0] eng_cos,
    output logic        busy
);

    // Handshake: a request transfers on a cycle where req_validk && req_readyk;
    // a response transfers on a cycle where resp_validk && resp_readyk.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] TLIM = 4'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        rr;
    logic        owner;
    logic        grant;
    logic        accept;
    logic        owner_ready;
    logic [21:0] ang_q;
    logic [21:0] res_q;
    logic        err_q;
    logic [3:0]  tcnt;

    // Contention goes to rr; otherwise the lone valid requester (0 when none).
    always_comb begin
        if (req_valid0 && req_valid1) begin
            grant = rr;
        end else begin
            grant = req_valid1;
        end
    end

    assign accept      = (state == IDLE) && (grant ? req_valid1 : req_valid0);
    assign owner_ready = owner ? resp_ready1 : resp_ready0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (eng_done || (tcnt == TLIM)) state_nxt = RESP;
            RESP:  if (owner_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr    <= 1'b0;
            owner <= 1'b0;
            ang_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            tcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ang_q <= grant ? req_angle1 : req_angle0;
                        owner <= grant;
                        rr    <= ~grant;
                    end
                end
                ISSUE: tcnt <= '0;
                WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (eng_done) begin
                        res_q <= eng_cos;
                        err_q <= 1'b0;
                    end else begin
                        if (tcnt == TLIM) begin
                            res_q <= '0;
                            err_q <= 1'b1;
                        end
                        if (tcnt != 4'hF) tcnt <= tcnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // req_ready is gated by reset because state already reads IDLE during reset.
    always_comb begin
        req_ready0  = reset && (state == IDLE) && !grant;
        req_ready1  = reset && (state == IDLE) && grant;
        eng_start   = (state == ISSUE);
        busy        = (state != IDLE);
        resp_valid0 = (state == RESP) && !owner;
        resp_valid1 = (state == RESP) && owner;
        resp_cos    = (state == RESP) ? res_q : '0;
        resp_err    = (state == RESP) ? err_q : 1'b0;
    end

    assign eng_angle = ang_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a small behavioural cosine engine
// (done rises four cycles after the start pulse, or never when hung).
module tb_cordic_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid0 = 1'b0;
    logic        req_valid1 = 1'b0;
    logic [21:0] req_angle0 = '0;
    logic [21:0] req_angle1 = '0;
    logic        req_ready0;
    logic        req_ready1;
    logic        resp_valid0;
    logic        resp_valid1;
    logic        resp_ready0 = 1'b1;
    logic        resp_ready1 = 1'b1;
    logic [21:0] resp_cos;
    logic        resp_err;
    logic        eng_start;
    logic [21:0] eng_angle;
    logic        eng_done;
    logic [21:0] eng_cos;
    logic        busy;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [1:0] eng_cnt;
    bit         eng_hang = 1'b0;

    cordic_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_angle0(req_angle0), .req_angle1(req_angle1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
        .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
        .resp_cos(resp_cos), .resp_err(resp_err),
        .eng_start(eng_start), .eng_angle(eng_angle),
        .eng_done(eng_done), .eng_cos(eng_cos), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- engine model ----------------
    function automatic logic [21:0] cos_of(input logic [21:0] a);
        case (a)
            22'h00000: cos_of = 22'h26DD3;
            22'h0C90F: cos_of = 22'h1B505;
            default:   cos_of = 22'h00001;
        endcase
    endfunction

    // done is a level that stays high until the next start is seen
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_cnt  <= 2'd0;
            eng_done <= 1'b0;
            eng_cos  <= '0;
        end else if (eng_start) begin
            eng_done <= 1'b0;
            eng_cnt  <= eng_hang ? 2'd0 : 2'd3;
        end else if (eng_cnt != 2'd0) begin
            eng_cnt <= eng_cnt - 2'd1;
            if (eng_cnt == 2'd1) begin
                eng_done <= 1'b1;
                eng_cos  <= cos_of(eng_angle);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit k, input logic [21:0] ang, output bit rdy);
        @(posedge clk); #1;
        if (k) begin req_valid1 = 1'b1; req_angle1 = ang; end
        else   begin req_valid0 = 1'b1; req_angle0 = ang; end
        @(negedge clk);
        rdy = k ? req_ready1 : req_ready0;
        @(posedge clk); #1;
        if (k) req_valid1 = 1'b0;
        else   req_valid0 = 1'b0;
    endtask

    task automatic wait_resp(input bit k, input int budget, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        while (!ok && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (k ? resp_valid1 : resp_valid0) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [50:0] outs;
        reset = 1'b0;
        req_valid0 = 1'b1;
        req_valid1 = 1'b1;
        repeat (2) @(negedge clk);
        outs = {req_ready0, req_ready1, resp_valid0, resp_valid1, resp_cos, resp_err,
                eng_start, eng_angle, busy};
        cmp_cnt++;
        if (outs !== 51'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0 || resp_valid0 !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_release: busy=%b resp_valid0=%b expected 0 0", busy, resp_valid0);
        end
    endtask

    task automatic test_single();
        bit rdy;
        issue(1'b0, 22'h00000, rdy);
        cmp_cnt++;
        if (rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_ready: got %b expected 1", rdy);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmp_cnt++;
                if (eng_start !== 1'b1 || busy !== 1'b1 || eng_angle !== 22'h0) begin
                    err_cnt++;
                    $display("FAIL single_issue: start=%b busy=%b angle=%h expected 1 1 0",
                             eng_start, busy, eng_angle);
                end
            end else if (c < 6) begin
                cmp_cnt++;
                if (eng_start !== 1'b0 || resp_valid0 !== 1'b0 || resp_cos !== 22'h0) begin
                    err_cnt++;
                    $display("FAIL single_wait c=%0d: start=%b rv0=%b cos=%h expected 0 0 0",
                             c, eng_start, resp_valid0, resp_cos);
                end
            end else begin
                cmp_cnt++;
                if (resp_valid0 !== 1'b1 || resp_valid1 !== 1'b0 ||
                    resp_cos !== 22'h26DD3 || resp_err !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL single_resp: rv0=%b rv1=%b cos=%h err=%b expected 1 0 26dd3 0",
                             resp_valid0, resp_valid1, resp_cos, resp_err);
                end
            end
        end
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [0:0] exp_q[$];
        logic [0:0] got;
        logic [0:0] cur_owner;
        logic [21:0] exp_cos;
        bit   have;
        int   n_grant;
        int   n_resp;
        int   cyc;
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        n_grant = 0;
        n_resp = 0;
        cyc = 0;
        cur_owner = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        req_angle0 = 22'h0C90F;
        req_angle1 = 22'h12D97;
        req_valid0 = 1'b1;
        req_valid1 = 1'b1;
        while (n_resp < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            have = 1'b0;
            got = 1'b0;
            if (req_ready0 && req_valid0) begin have = 1'b1; got = 1'b0; end
            else if (req_ready1 && req_valid1) begin have = 1'b1; got = 1'b1; end
            if (have) begin
                cmp_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL rr_extra_grant: got %0d expected none", got);
                end else if (got !== exp_q[0]) begin
                    err_cnt++;
                    $display("FAIL rr_order grant %0d: got %0d expected %0d", n_grant, got, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                cur_owner = got;
                n_grant++;
            end
            if (resp_valid0 || resp_valid1) begin
                exp_cos = cur_owner ? 22'h00001 : 22'h1B505;
                cmp_cnt++;
                if (resp_valid0 !== ~cur_owner || resp_valid1 !== cur_owner || resp_cos !== exp_cos) begin
                    err_cnt++;
                    $display("FAIL rr_resp owner %0d: rv0=%b rv1=%b cos=%h expected cos %h",
                             cur_owner, resp_valid0, resp_valid1, resp_cos, exp_cos);
                end
                n_resp++;
            end
            if (n_grant == 4 && (req_valid0 || req_valid1)) begin
                @(posedge clk); #1;
                req_valid0 = 1'b0;
                req_valid1 = 1'b0;
            end
        end
        cmp_cnt++;
        if (n_resp != 4 || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL rr_count: responses=%0d grants_left=%0d expected 4 0", n_resp, exp_q.size());
        end
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
    endtask

    task automatic test_back_pressure();
        bit rdy;
        bit ok;
        int cyc;
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b1;
        issue(1'b0, 22'h0C90F, rdy);
        req_angle1 = 22'h12D97;
        req_valid1 = 1'b1;
        wait_resp(1'b0, 20, ok, cyc);
        cmp_cnt++;
        if (!ok || cyc != 6 || rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_latency: ok=%b cycles=%0d rdy=%b expected 1 6 1", ok, cyc, rdy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if (resp_valid0 !== 1'b1 || resp_cos !== 22'h1B505 || req_ready1 !== 1'b0 ||
                req_ready0 !== 1'b0 || resp_valid1 !== 1'b0) begin
                err_cnt++;
                $display("FAIL bp_hold %0d: rv0=%b cos=%h rr0=%b rr1=%b rv1=%b expected 1 1b505 0 0 0",
                         i, resp_valid0, resp_cos, req_ready0, req_ready1, resp_valid1);
            end
        end
        @(posedge clk); #1;
        resp_ready0 = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (resp_valid0 !== 1'b1 || req_ready1 !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_exit_cycle: rv0=%b rr1=%b expected 1 0", resp_valid0, req_ready1);
        end
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0 || req_ready1 !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_idle: busy=%b rr1=%b expected 0 1", busy, req_ready1);
        end
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        wait_resp(1'b1, 20, ok, cyc);
        cmp_cnt++;
        if (!ok || cyc != 6 || resp_cos !== 22'h00001) begin
            err_cnt++;
            $display("FAIL bp_next: ok=%b cycles=%0d cos=%h expected 1 6 00001", ok, cyc, resp_cos);
        end
    endtask

    task automatic test_timeout();
        bit rdy;
        bit ok;
        int cyc;
        eng_hang = 1'b1;
        issue(1'b0, 22'h00000, rdy);
        wait_resp(1'b0, 30, ok, cyc);
        cmp_cnt++;
        if (!ok || cyc != 17 || resp_err !== 1'b1 || resp_cos !== 22'h0) begin
            err_cnt++;
            $display("FAIL timeout_resp: ok=%b cycles=%0d err=%b cos=%h expected 1 17 1 0",
                     ok, cyc, resp_err, resp_cos);
        end
        eng_hang = 1'b0;
        issue(1'b1, 22'h12D97, rdy);
        wait_resp(1'b1, 20, ok, cyc);
        cmp_cnt++;
        if (!ok || cyc != 6 || resp_err !== 1'b0 || resp_cos !== 22'h00001) begin
            err_cnt++;
            $display("FAIL timeout_recover: ok=%b cycles=%0d err=%b cos=%h expected 1 6 0 00001",
                     ok, cyc, resp_err, resp_cos);
        end
    endtask

    task automatic test_stale_done();
        bit rdy;
        bit ok;
        int cyc;
        issue(1'b0, 22'h0C90F, rdy);
        wait_resp(1'b0, 20, ok, cyc);
        cmp_cnt++;
        if (!ok || cyc != 6 || resp_cos !== 22'h1B505 || resp_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL stale_done: ok=%b cycles=%0d cos=%h err=%b expected 1 6 1b505 0",
                     ok, cyc, resp_cos, resp_err);
        end
    endtask

    task automatic test_mid_reset();
        bit rdy;
        bit ok;
        int cyc;
        logic [50:0] outs;
        issue(1'b0, 22'h0C90F, rdy);
        @(negedge clk);
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL midrst_busy: got %b expected 1", busy);
        end
        #2;
        req_angle0 = 22'h0C90F;
        req_angle1 = 22'h12D97;
        req_valid0 = 1'b1;
        req_valid1 = 1'b1;
        reset = 1'b0;
        #1;
        outs = {req_ready0, req_ready1, resp_valid0, resp_valid1, resp_cos, resp_err,
                eng_start, eng_angle, busy};
        cmp_cnt++;
        if (outs !== 51'd0) begin
            err_cnt++;
            $display("FAIL midrst_outputs: got %h expected 0", outs);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        cmp_cnt++;
        if (req_ready0 !== 1'b1 || req_ready1 !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrst_first_grant: rr0=%b rr1=%b expected 1 0", req_ready0, req_ready1);
        end
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        wait_resp(1'b0, 20, ok, cyc);
        cmp_cnt++;
        if (!ok || cyc != 6 || resp_cos !== 22'h1B505) begin
            err_cnt++;
            $display("FAIL midrst_after: ok=%b cycles=%0d cos=%h expected 1 6 1b505", ok, cyc, resp_cos);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_back_pressure();
        test_timeout();
        test_stale_done();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
